pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-width, always-advancing inter-stage latches (IF/ID … MEM/WB) of the pipelined CPU. It adds stall back-pressure, flush-to-bubble, and full throughput, while keeping the upstream ready signal free of any combinational path from downstream ready. One instance sits between each pair of pipeline stages; the stage's control/data fields are concatenated into one bus.

## Interface
Parameters:
- DATA_W, 72, width of the packed stage bundle (MEM/WB default: WB 2 + RD 32 + ADDRESS 32 + WN 5 + Jal 1).
- BUBBLE_VAL, '0, value driven on out_data and loaded into both slots on reset and flush. All-zero control fields mean no writeback and no jump.

Ports:
- clk, in, 1, sole clock; all state updates on posedge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, upstream stage presents a beat.
- in_ready, out, 1, block accepts a beat this cycle.
- in_data, in, DATA_W, upstream bundle.
- flush, in, 1, synchronous kill of all held beats and the incoming beat.
- out_valid, out, 1, out_data holds a live beat.
- out_ready, in, 1, downstream consumes the beat this cycle.
- out_data, out, DATA_W, bundle to next stage.
- occupancy, out, 2, number of held beats (0..2).

## Operation
- Storage: main slot (drives out_data) and skid slot. State is EMPTY, ONE, or TWO (occupancy 0/1/2).
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- in_ready = (state != TWO) & !flush. It is registered state plus the flush gate only; it never depends on out_ready.
- out_valid = (state != EMPTY).
- Transitions (rst and flush not asserted):
  - EMPTY: in_fire → ONE, main ← in_data; otherwise stay.
  - ONE, in_fire & out_fire: stay ONE, main ← in_data.
  - ONE, in_fire & !out_fire: → TWO, skid ← in_data.
  - ONE, !in_fire & out_fire: → EMPTY, main ← BUBBLE_VAL.
  - ONE, neither: hold.
  - TWO, out_fire: → ONE, main ← skid, skid ← BUBBLE_VAL.
  - TWO, otherwise: hold. in_ready = 0, so no input can arrive.
- Priority: rst > flush > handshake.
- flush = 1: next state EMPTY, main and skid ← BUBBLE_VAL. The incoming beat is dropped: in_ready is forced to 0 that cycle, so upstream sees no acceptance. An out_fire occurring in the flush cycle still counts as consumed by downstream.
- Ordering: strictly FIFO. The skid beat is always younger than the main beat.
- Hold rule: while out_valid & !out_ready, out_data is stable cycle to cycle.
- out_data equals BUBBLE_VAL whenever out_valid = 0.
- No arithmetic. Data is never modified, only moved.

## Timing
- Reset (rst sampled high at posedge) gives, from the next cycle:
  - state EMPTY, occupancy 0, out_valid 0, out_data BUBBLE_VAL.
  - main = skid = BUBBLE_VAL.
  - in_ready is 0 while rst = 1 and 1 after rst deasserts.
- Latency: a beat accepted at edge N appears on out_data with out_valid = 1 in cycle N+1.
- Throughput: one beat per cycle when out_ready is held high; the skid slot is never used.
- Stall: out_ready low for k cycles with in_valid high. One extra beat is absorbed into skid, then in_ready drops in the cycle after that beat is accepted.
- Release from TWO: in_ready returns to 1 one cycle after the first out_fire.
- Reset or flush in the middle of TWO discards both beats. No partial state survives.
- flush and rst together: identical result to rst.

## Structure
- Shared package pipe_pkg:
  - field widths: WB_W = 2, WORD_W = 32, REG_W = 5, MEMWB_W = 72.
  - the state enum (EMPTY, ONE, TWO).
  - pack/unpack functions for the MEM/WB bundle.
- Single flat module. No sub-module is natural; the two slots differ only in their load sources.

## Test plan
- Reset then pass-through: rst 2 cycles, out_ready = 1, in_data = 0x...A5 then 0x...5A on consecutive cycles → out_data shows each value one cycle later, out_valid 1, occupancy 1, in_ready stays 1.
- Stall fill: out_ready = 0, send beats B0, B1, B2 → B0 and B1 accepted, occupancy 2, in_ready = 0 from the cycle after B1, B2 held upstream. With out_ready still 0 and B2 still offered, out_data = B0 unchanged.
- Drain order: from the full state, out_ready = 1 → out_data B0, then B1, then B2 (B2 accepted once in_ready = 1). No duplication or loss.
- Flush with two held beats and in_valid = 1 → in_ready = 0 that cycle. Next cycle: out_valid 0, occupancy 0, out_data = BUBBLE_VAL. The flushed input beat never appears downstream.
- Mid-operation reset in TWO → next cycle identical to post-reset values. in_ready = 0 during rst, 1 after.
- Random valid/ready with a scoreboard over 10k cycles (DATA_W = 72 and DATA_W = 8) → in-order delivery, no loss, and in_ready never depends combinationally on out_ready (check by toggling out_ready within a cycle).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB field widths, skid-register state and
// helpers to pack/unpack the MEM/WB stage bundle.
package pipe_pkg;

    localparam int WB_W    = 2;
    localparam int WORD_W  = 32;
    localparam int REG_W   = 5;
    localparam int MEMWB_W = WB_W + WORD_W + WORD_W + REG_W + 1;

    // Encoding equals the number of held beats, so it doubles as occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [WORD_W-1:0] rd;
        logic [WORD_W-1:0] address;
        logic [REG_W-1:0]  wn;
        logic              jal;
    } memwb_t;

    function automatic logic [MEMWB_W-1:0] pack_memwb(input memwb_t f);
        return f;
    endfunction

    function automatic memwb_t unpack_memwb(input logic [MEMWB_W-1:0] bits);
        return memwb_t'(bits);
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid
// buffer; in_ready comes from registered state and flush/rst only.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = MEMWB_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] main_reg, main_next;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              in_fire, out_fire;

    // Deliberately independent of out_ready to break the ready chain.
    assign in_ready  = (state_reg != TWO) & ~flush & ~rst;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;
    assign occupancy = 2'(state_reg);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = EMPTY;
            main_next  = BUBBLE_VAL;
            skid_next  = BUBBLE_VAL;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (in_fire) begin
                        state_next = TWO;
                        skid_next  = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                        main_next  = BUBBLE_VAL;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_next = ONE;
                        main_next  = skid_reg;
                        skid_next  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = BUBBLE_VAL;
                    skid_next  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= BUBBLE_VAL;
            skid_reg  <= BUBBLE_VAL;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random bench for pipe_skid_reg (72-bit and 8-bit instances)
// against a queue-based FIFO reference model.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;
    logic [1:0]  occupancy;

    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        out_valid8;
    logic [7:0]  out_data8;
    logic [1:0]  occupancy8;

    int total = 0;
    int bad   = 0;
    logic [71:0] mq[$];
    logic [95:0] rnd;

    assign in_data8 = in_data[7:0];

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(72)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
    );

    pipe_skid_reg #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data8), .flush(flush), .out_valid(out_valid8),
        .out_ready(out_ready), .out_data(out_data8), .occupancy(occupancy8)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare all outputs with the model at negedge, probe
    // out_ready independence, then advance the model at posedge.
    task automatic cycle();
        logic        exp_ready, exp_valid, in_fire, out_fire;
        logic [71:0] exp_data;
        @(negedge clk);
        exp_ready = (mq.size() < 2) && !flush && !rst;
        exp_valid = (mq.size() != 0);
        exp_data  = exp_valid ? mq[0] : 72'd0;
        check("in_ready",   {71'd0, in_ready},   {71'd0, exp_ready});
        check("out_valid",  {71'd0, out_valid},  {71'd0, exp_valid});
        check("out_data",   out_data,            exp_data);
        check("occupancy",  {70'd0, occupancy},  72'(mq.size()));
        check("in_ready8",  {71'd0, in_ready8},  {71'd0, exp_ready});
        check("out_valid8", {71'd0, out_valid8}, {71'd0, exp_valid});
        check("out_data8",  {64'd0, out_data8},  {64'd0, exp_data[7:0]});
        out_ready = ~out_ready;
        #1;
        check("in_ready_no_comb_path", {71'd0, in_ready}, {71'd0, exp_ready});
        out_ready = ~out_ready;
        #1;
        in_fire  = in_valid && exp_ready;
        out_fire = exp_valid && out_ready;
        if (out_valid && out_ready) begin
            $display("cycle t=%0t out_fire data=%h occ=%0d", $time, out_data, occupancy);
        end
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (out_fire) void'(mq.pop_front());
            if (in_fire) mq.push_back(in_data);
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Pass-through at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 72'hA5A5_A5A5_A5A5_A5A5_A5; cycle();
        in_data = 72'h5A5A_5A5A_5A5A_5A5A_5A; cycle();
        in_valid = 1'b0; cycle();
        cycle();

        // Stall fill: B0, B1 absorbed; B2 held upstream
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 72'hB0; cycle();
        in_data = 72'hB1; cycle();
        in_data = 72'hB2; cycle(); cycle(); cycle();

        // Drain: B2 stays offered until accepted
        out_ready = 1'b1;
        cycle(); cycle();
        in_valid = 1'b0;
        cycle(); cycle();

        // Flush with two held beats and an offered beat
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 72'hC0; cycle();
        in_data = 72'hC1; cycle();
        in_data = 72'hC2; flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0; cycle();
        out_ready = 1'b1; cycle();

        // Reset in the middle of TWO
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 72'hD0; cycle();
        in_data = 72'hD1; cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; in_valid = 1'b0; cycle();

        // Random valid/ready/flush traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            flush     = ($urandom_range(63) == 0);
            rnd       = {$urandom, $urandom, $urandom};
            in_data   = rnd[71:0];
            cycle();
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();
        check("final_empty", {70'd0, occupancy}, 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
